// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC, synchronous-read memory addressing, 2-entry queue to decode.
// Optional FETCH_HALT_AT_END_EN stops fetch when the PC reaches PROG_WORDS.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_PC   = 0,
  parameter int PROG_WORDS = 54
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] END_PC = ADDR_WIDTH'(PROG_WORDS);
`ifdef FETCH_HALT_AT_END_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [DATA_WIDTH-1:0] q_data_q [2];
  logic [DATA_WIDTH-1:0] q_data_d [2];
  logic [ADDR_WIDTH-1:0] q_pc_q [2];
  logic [ADDR_WIDTH-1:0] q_pc_d [2];
  logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  halted_q, halted_d;

  logic       pop, push, issue, at_end;
  logic [2:0] occ;

  always_comb begin
    pop    = (count_q != 2'd0) && instr_ready;
    push   = inflight_q && !redirect;
    at_end = HALT_EN && (fetch_pc_q == END_PC);
    occ    = {1'b0, count_q} + {2'b0, inflight_q};
    // Only issue if the word will have a queue slot when it lands next cycle.
    issue  = !redirect && !halted_q && !at_end && (occ <= 3'd1 + {2'b0, pop});

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    q_data_d      = q_data_q;
    q_pc_d        = q_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    halted_d      = halted_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      halted_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        q_data_d[wr_ptr_q] = dataOut;
        q_pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d           = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (at_end && !inflight_q) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RST_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      q_data_q[0]   <= '0;
      q_data_q[1]   <= '0;
      q_pc_q[0]     <= '0;
      q_pc_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      q_data_q      <= q_data_d;
      q_pc_q        <= q_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
    end
  end

  assign address     = fetch_pc_q;
  assign instr       = q_data_q[rd_ptr_q];
  assign instr_pc    = q_pc_q[rd_ptr_q];
  assign instr_valid = (count_q != 2'd0);
  assign halted      = halted_q;

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == 2'd2));
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle table plus wrap, mid-stream reset and optional halt sequences.
module tb_instruction_fetch;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, instr_ready, redirect, instr_valid, halted;
  logic [AW-1:0] address, instr_pc, redirect_pc;
  logic [DW-1:0] dataOut, instr;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .address(address), .dataOut(dataOut),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: mem[k] = A5000000 + k
  always @(posedge clk) dataOut <= 32'hA500_0000 + {22'd0, address};

  typedef struct packed {
    logic          rst;
    logic          rdy;
    logic          rd;
    logic [AW-1:0] rpc;
    logic          ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tv [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic ev, input logic [AW-1:0] epc,
                         input logic [AW-1:0] eaddr);
    chk({tag, " valid"}, {31'd0, instr_valid}, {31'd0, ev});
    chk({tag, " address"}, {22'd0, address}, {22'd0, eaddr});
    chk({tag, " halted"}, {31'd0, halted}, 32'd0);
    if (ev) begin
      chk({tag, " instr_pc"}, {22'd0, instr_pc}, {22'd0, epc});
      chk({tag, " instr"}, instr, 32'hA500_0000 + {22'd0, epc});
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [AW-1:0] rpc);
    rst = r; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // rows: rst rdy rd rpc | valid pc address (cycle 0 = first cycle with rst low)
    tv[0]  = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd0,   10'd2};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd1,   10'd3};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd2,   10'd4};
    tv[10] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd3,   10'd5};
    tv[11] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd4,   10'd6};
    tv[12] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd5,   10'd7};
    tv[13] = '{1'b0, 1'b1, 1'b1, 10'd40,  1'b1, 10'd6,   10'd8};
    tv[14] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd40};
    tv[15] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd41};
    tv[16] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd40,  10'd42};
    tv[17] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd41,  10'd43};
    tv[18] = '{1'b0, 1'b1, 1'b1, 10'd100, 1'b1, 10'd42,  10'd44};
    tv[19] = '{1'b0, 1'b1, 1'b1, 10'd200, 1'b0, 10'd0,   10'd100};
    tv[20] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd200};
    tv[21] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,   10'd201};
    tv[22] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd200, 10'd202};
    tv[23] = '{1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 10'd201, 10'd203};

    drive(1'b1, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    next_cyc();
    next_cyc();
    chk("reset instr", instr, 32'd0);
    chk("reset instr_pc", {22'd0, instr_pc}, 32'd0);
    exp_out("reset", 1'b0, 10'd0, 10'd0);

    for (int i = 0; i < 24; i++) begin
      drive(tv[i].rst, tv[i].rdy, tv[i].rd, tv[i].rpc);
      exp_out($sformatf("cyc%0d", i), tv[i].ev, tv[i].epc, tv[i].eaddr);
      next_cyc();
    end

    // Wrap: redirect to 1022, expect 1022, 1023, 0, 1
    drive(1'b0, 1'b1, 1'b1, 10'd1022);
    next_cyc();
    drive(1'b0, 1'b1, 1'b0, 10'd0);
    exp_out("wrap r+1", 1'b0, 10'd0, 10'd1022); next_cyc();
    exp_out("wrap r+2", 1'b0, 10'd0, 10'd1023); next_cyc();
    exp_out("wrap r+3", 1'b1, 10'd1022, 10'd0); next_cyc();
    exp_out("wrap r+4", 1'b1, 10'd1023, 10'd1); next_cyc();
    exp_out("wrap r+5", 1'b1, 10'd0, 10'd2);    next_cyc();
    exp_out("wrap r+6", 1'b1, 10'd1, 10'd3);

    // Stall to fill the queue, then reset mid-stream
    drive(1'b0, 1'b0, 1'b0, 10'd0);
    next_cyc();
    exp_out("full", 1'b1, 10'd1, 10'd3);
    drive(1'b1, 1'b0, 1'b1, 10'd500);
    next_cyc();
    drive(1'b0, 1'b1, 1'b0, 10'd0);
    exp_out("rst c0", 1'b0, 10'd0, 10'd0);
    chk("rst c0 instr", instr, 32'd0);
    next_cyc();
    exp_out("rst c1", 1'b0, 10'd0, 10'd1); next_cyc();
    exp_out("rst c2", 1'b1, 10'd0, 10'd2); next_cyc();
    exp_out("rst c3", 1'b1, 10'd1, 10'd3);

`ifdef FETCH_HALT_AT_END_EN
    begin
      int delivered;
      int last_pc;
      bit done;
      delivered = 0; last_pc = -1; done = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 10'd0);
      next_cyc();
      drive(1'b0, 1'b1, 1'b0, 10'd0);
      for (int c = 0; c < 150 && !done; c++) begin
        if (instr_valid && instr_ready) begin
          if ({22'd0, instr_pc} != 32'(delivered))
            $display("FAIL halt order: got pc %0d expected %0d", instr_pc, delivered);
          delivered++; last_pc = int'(instr_pc);
        end
        if (halted && !instr_valid) done = 1'b1;
        else next_cyc();
      end
      chk("halt reached", {31'd0, done}, 32'd1);
      chk("halt delivered", delivered, 32'd54);
      chk("halt last pc", last_pc, 32'd53);
      chk("halt address", {22'd0, address}, 32'd54);
      next_cyc();
      chk("halt holds", {31'd0, halted}, 32'd1);
      chk("halt addr holds", {22'd0, address}, 32'd54);
      drive(1'b0, 1'b1, 1'b1, 10'd0);
      next_cyc();
      drive(1'b0, 1'b1, 1'b0, 10'd0);
      chk("halt cleared", {31'd0, halted}, 32'd0);
      next_cyc();
      next_cyc();
      chk("restart valid", {31'd0, instr_valid}, 32'd1);
      chk("restart pc", {22'd0, instr_pc}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
